// File: rtl/sd_decimator_if.sv
// rtl/sd_decimator_if.sv - bitstream-in / PCM-out signal bundle for sd_decimator
//
// Purpose: groups the sigma-delta input qualifier pair and the PCM output
// strobe group so the decimator and its driver share one connection.
// Signals:
//   bit_i        sigma-delta sample, 1 -> +1, 0 -> -1
//   bit_valid_i  qualifies bit_i on each rising clock edge
//   pcm_o        signed BW-bit decimated sample, held between strobes
//   valid_o      one-cycle strobe marking a new pcm_o
//   clip_o       high with valid_o when pcm_o was saturated
// Modports: master drives the bitstream, slave (the decimator) drives PCM.

interface sd_decimator_if #(
  parameter int BW = 16
) ();
  logic                 bit_i;
  logic                 bit_valid_i;
  logic signed [BW-1:0] pcm_o;
  logic                 valid_o;
  logic                 clip_o;

  modport master (
    output bit_i,
    output bit_valid_i,
    input  pcm_o,
    input  valid_o,
    input  clip_o
  );

  modport slave (
    input  bit_i,
    input  bit_valid_i,
    output pcm_o,
    output valid_o,
    output clip_o
  );
endinterface

// File: rtl/sd_decimator.sv
// rtl/sd_decimator.sv - 3rd-order CIC decimator for a 1-bit sigma-delta stream
//
// Purpose: integrates accepted bits (+1/-1) in three cascaded integrators,
// every R = 2^DEC_LOG2 accepted bits runs a 3-stage comb on the captured
// integrator value, then scales by 2^-S, saturates to BW bits and presents
// the result one clock after the decimation edge.
// Ports:
//   clk_i  single clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    sd_decimator_if.slave (bit_i, bit_valid_i in; pcm_o, valid_o, clip_o out)
// Parameters:
//   BW        PCM output width (signed)
//   DEC_LOG2  log2 of decimation ratio; requires 3*DEC_LOG2 >= BW-1

module sd_decimator #(
  parameter int BW       = 16,
  parameter int DEC_LOG2 = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sd_decimator_if.slave  bus
);
  localparam int ACC_W = 2 + 3 * DEC_LOG2;
  localparam int SHIFT = 3 * DEC_LOG2 - (BW - 1);
  localparam logic signed [ACC_W-1:0] P_MAX = ACC_W'((1 << (BW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] P_MIN = ACC_W'(-(1 << (BW - 1)));

  // Integrators, comb delays and the registered comb result. All arithmetic
  // is modulo 2^ACC_W; integrator wrap-around cancels in the comb.
  logic signed [ACC_W-1:0] r_i1, r_i2, r_i3;
  logic signed [ACC_W-1:0] r_z1, r_z2, r_z3;
  logic signed [ACC_W-1:0] r_c3;
  logic [DEC_LOG2-1:0]     r_cnt;
  logic                    r_strobe;

  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_d1, w_d2, w_d3;
  logic signed [ACC_W-1:0] w_shift;
  logic                    w_dec;
  logic                    w_hi, w_lo;
  logic signed [BW-1:0]    w_pcm;

  assign w_x   = bus.bit_i ? ACC_W'(1) : '1;
  assign w_dec = bus.bit_valid_i && (&r_cnt);

  // Comb chain works on the pre-update I3 value of the decimation edge.
  assign w_d1 = r_i3 - r_z1;
  assign w_d2 = w_d1 - r_z2;
  assign w_d3 = w_d2 - r_z3;

  // Arithmetic shift floors toward minus infinity before saturation.
  assign w_shift = r_c3 >>> SHIFT;
  assign w_hi    = (w_shift > P_MAX);
  assign w_lo    = (w_shift < P_MIN);
  assign w_pcm   = w_hi ? P_MAX[BW-1:0] :
                   w_lo ? P_MIN[BW-1:0] :
                          w_shift[BW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_i1        <= '0;
      r_i2        <= '0;
      r_i3        <= '0;
      r_z1        <= '0;
      r_z2        <= '0;
      r_z3        <= '0;
      r_c3        <= '0;
      r_cnt       <= '0;
      r_strobe    <= 1'b0;
      bus.pcm_o   <= '0;
      bus.valid_o <= 1'b0;
      bus.clip_o  <= 1'b0;
    end else begin
      if (bus.bit_valid_i) begin
        r_i1  <= r_i1 + w_x;
        r_i2  <= r_i2 + r_i1;
        r_i3  <= r_i3 + r_i2;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_dec) begin
        r_z1 <= r_i3;
        r_z2 <= w_d1;
        r_z3 <= w_d2;
        r_c3 <= w_d3;
      end
      // Scaling/saturation happen in the cycle after capture so the
      // output registers update one clock after the decimation edge.
      r_strobe    <= w_dec;
      bus.valid_o <= r_strobe;
      bus.clip_o  <= r_strobe & (w_hi | w_lo);
      if (r_strobe) begin
        bus.pcm_o <= w_pcm;
      end
    end
  end
endmodule

// File: tb/tb_sd_decimator.sv
// tb/tb_sd_decimator.sv - self-checking bench for sd_decimator

module tb_sd_decimator;
  localparam int BW    = 16;
  localparam int DL    = 5;
  localparam int R     = 1 << DL;
  localparam int ACC_W = 2 + 3 * DL;
  localparam int S     = 3 * DL - (BW - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  sd_decimator_if #(.BW(BW)) bus ();

  sd_decimator #(.BW(BW), .DEC_LOG2(DL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     cyc;
  int     idle_clip;
  int     xs[$];
  longint pcm_q[$];
  int     clip_q[$];
  int     acc_q[$];
  int     cyc_q[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic tick(input logic r, input logic b, input logic v);
    int acc_before;
    rst             = r;
    bus.bit_i       = b;
    bus.bit_valid_i = v;
    acc_before      = xs.size();
    @(posedge clk);
    #1;
    cyc++;
    if (!r && v) xs.push_back(b ? 1 : -1);
    if (bus.valid_o) begin
      pcm_q.push_back(longint'(bus.pcm_o));
      clip_q.push_back(int'(bus.clip_o));
      acc_q.push_back(acc_before);
      cyc_q.push_back(cyc);
    end else if (bus.clip_o) begin
      idle_clip++;
    end
  endtask

  task automatic clear_log();
    xs.delete();
    pcm_q.delete();
    clip_q.delete();
    acc_q.delete();
    cyc_q.delete();
    cyc       = 0;
    idle_clip = 0;
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b1, 1'($urandom), 1'b1);
    clear_log();
  endtask

  // Reference model: third integrator after k samples is the sum of
  // x_j * C(k-1-j, 2); the comb is the third backward difference of the
  // values sampled every R inputs, reduced modulo 2^ACC_W.
  function automatic longint i3_after(input int k);
    longint s = 0;
    for (int j = 0; j < k; j++) begin
      longint n = longint'(k - 1 - j);
      s += longint'(xs[j]) * n * (n - 1) / 2;
    end
    return s;
  endfunction

  function automatic longint v_of(input int f);
    if (f < 0) return 0;
    return i3_after((f + 1) * R - 1);
  endfunction

  function automatic longint wrap_acc(input longint v);
    longint m = v & ((64'sd1 <<< ACC_W) - 1);
    if (m >= (64'sd1 <<< (ACC_W - 1))) m -= (64'sd1 <<< ACC_W);
    return m;
  endfunction

  task automatic model(input int f, output longint pcm, output int clip);
    longint c, sh, hi, lo;
    c  = wrap_acc(v_of(f) - 3 * v_of(f - 1) + 3 * v_of(f - 2) - v_of(f - 3));
    sh = c >>> S;
    hi = (64'sd1 <<< (BW - 1)) - 1;
    lo = -(64'sd1 <<< (BW - 1));
    clip = 0;
    pcm  = sh;
    if (sh > hi) begin pcm = hi; clip = 1; end
    if (sh < lo) begin pcm = lo; clip = 1; end
  endtask

  function automatic logic pat_bit(input int pat, input int i);
    case (pat)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2) == 0;
      3:       return (i % 4) != 3;
      default: return 1'($urandom);
    endcase
  endfunction

  // gap: 0 = always valid, 1 = valid every other cycle, 2 = random gaps
  task automatic run(input string tag, input int pat, input int gap, input int nframes,
                     input int use_model, input int has_steady,
                     input longint steady, input int steady_clip);
    int     budget;
    int     need;
    logic   v;
    longint mp;
    int     mc;
    do_reset();
    need   = nframes * R;
    budget = need * 4 + 20;
    while (xs.size() < need && budget > 0) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      tick(1'b0, v ? pat_bit(pat, xs.size()) : 1'($urandom), v);
      budget--;
    end
    check({tag, " cycle budget"}, longint'(budget > 0), 1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check({tag, " strobe count"}, pcm_q.size(), nframes);
    if (gap == 0 && cyc_q.size() > 0)
      check({tag, " first strobe cycle"}, cyc_q[0], R + 1);
    for (int f = 0; f < pcm_q.size() && f < nframes; f++) begin
      check($sformatf("%s spacing[%0d]", tag, f), acc_q[f], (f + 1) * R);
      if (use_model != 0) begin
        model(f, mp, mc);
        check($sformatf("%s pcm[%0d]", tag, f), pcm_q[f], mp);
        check($sformatf("%s clip[%0d]", tag, f), clip_q[f], mc);
      end
      if (has_steady != 0 && f >= 3) begin
        check($sformatf("%s steady pcm[%0d]", tag, f), pcm_q[f], steady);
        check($sformatf("%s steady clip[%0d]", tag, f), clip_q[f], steady_clip);
      end
    end
    check({tag, " clip while idle"}, idle_clip, 0);
  endtask

  initial begin
    longint mp;
    int     mc;
    bus.bit_i       = 1'b0;
    bus.bit_valid_i = 1'b0;
    clear_log();

    // Reset state, with bit_valid_i high to show it is ignored.
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    check("reset pcm", longint'(bus.pcm_o), 0);
    check("reset valid", longint'(bus.valid_o), 0);
    check("reset clip", longint'(bus.clip_o), 0);

    run("ones",        0, 0, 6,  1, 1, 32767,  1);
    run("zeros",       1, 0, 6,  1, 1, -32768, 0);
    run("alt",         2, 0, 6,  1, 1, 0,      0);
    run("alt toggle",  2, 1, 6,  1, 1, 0,      0);
    run("alt gaps",    2, 2, 6,  1, 1, 0,      0);
    run("1110",        3, 0, 6,  1, 1, 16384,  0);
    run("1110 toggle", 3, 1, 6,  1, 1, 16384,  0);
    run("1110 gaps",   3, 2, 6,  1, 1, 16384,  0);
    run("random gaps", 4, 2, 12, 1, 0, 0,      0);

    // Reset after 20 accepted bits discards the partial frame.
    do_reset();
    repeat (20) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("midreset pcm", longint'(bus.pcm_o), 0);
    check("midreset valid", longint'(bus.valid_o), 0);
    check("midreset clip", longint'(bus.clip_o), 0);
    clear_log();
    repeat (32) tick(1'b0, 1'b1, 1'b1);
    check("midreset no early strobe", pcm_q.size(), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("midreset strobe count", pcm_q.size(), 1);
    if (pcm_q.size() > 0) begin
      model(0, mp, mc);
      check("midreset strobe cycle", cyc_q[0], R + 1);
      check("midreset pcm value", pcm_q[0], mp);
    end

    // Reset coinciding with the decimation edge wins.
    do_reset();
    repeat (R - 1) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("reset on decimation edge", pcm_q.size(), 0);

    // Long constant-ones run: integrators wrap many times.
    run("long ones", 0, 0, 625, 0, 1, 32767, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
